parc_bypass_scoreboard: RTL and testbench

//  Parametrised hazard scoreboard and bypass controller for the PARCv2 pipeline. It

---
 rtl/parc_bypass_scoreboard.sv | 151 +++++++++++++++
 tb/tb_parc_bypass_scoreboard.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parc_bypass_scoreboard.sv
// ---------------------------------------------------------------------------
// parc_bypass_scoreboard
//   Hazard scoreboard and bypass controller for the PARCv2 pipeline.
//   Tracks in-flight register writes from X through W (one entry per stage).
//   Drives the D-stage stall and one bypass-select code per source operand.
//
//   Optional feature macro: PARC_SB_WB_BYPASS_EN
//     defined   : stage PIPE_DEPTH (W) is a legal bypass source.
//     undefined : a youngest match sitting in W is a hazard. D waits until
//                 the register-file write has landed.
// ---------------------------------------------------------------------------
module parc_bypass_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int PIPE_DEPTH = 3,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_val_Dhl,
    input  logic                      issue_wen_Dhl,
    input  logic [REG_AW-1:0]         issue_waddr_Dhl,
    input  logic [SEL_W-1:0]          issue_lat_Dhl,
    input  logic                      squash_Dhl,
    input  logic [NUM_SRC-1:0]        src_val_Dhl,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr_Dhl,
    input  logic                      advance,
    output logic                      stall_Dhl,
    output logic [NUM_SRC*SEL_W-1:0]  byp_sel_Dhl,
    output logic [CNT_W-1:0]          stall_cnt
);

    // Entry index k holds the instruction in stage k+1 (index 0 = X).
    logic [PIPE_DEPTH-1:0]             r_val;
    logic [PIPE_DEPTH-1:0][REG_AW-1:0] r_waddr;
    logic [PIPE_DEPTH-1:0][SEL_W-1:0]  r_rdy;
    logic [CNT_W-1:0]                  r_stall_cnt;

    logic [SEL_W-1:0]   w_lat;
    logic [NUM_SRC-1:0] w_haz_vec;
    logic               w_insert;

    // Normalise the result latency: 0 means "ready in X", large values clamp to W.
    always_comb begin
        w_lat = issue_lat_Dhl;
        if (issue_lat_Dhl == {SEL_W{1'b0}}) begin
            w_lat = SEL_W'(1);
        end else if (issue_lat_Dhl > SEL_W'(PIPE_DEPTH)) begin
            w_lat = SEL_W'(PIPE_DEPTH);
        end else begin
            w_lat = issue_lat_Dhl;
        end
    end

    genvar gs;
    generate
        for (gs = 0; gs < NUM_SRC; gs++) begin : g_src
            logic [REG_AW-1:0] w_addr;
            logic              w_found;
            logic [SEL_W-1:0]  w_stage;
            logic [SEL_W-1:0]  w_rdy;
            logic              w_haz;
            logic [SEL_W-1:0]  w_sel;

            assign w_addr = src_addr_Dhl[gs*REG_AW +: REG_AW];

            // Youngest matching entry: scan oldest to youngest so the lowest stage wins.
            always_comb begin
                w_found = 1'b0;
                w_stage = {SEL_W{1'b0}};
                w_rdy   = {SEL_W{1'b0}};
                for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
                    if (r_val[k] && (r_waddr[k] == w_addr)) begin
                        w_found = 1'b1;
                        w_stage = SEL_W'(k + 1);
                        w_rdy   = r_rdy[k];
                    end else begin
                        w_found = w_found;
                    end
                end
            end

            // Classify the match: regfile read, bypass from stage k, or hazard.
            always_comb begin
                w_haz = 1'b0;
                w_sel = {SEL_W{1'b0}};
                if (!reset || !src_val_Dhl[gs] || (w_addr == {REG_AW{1'b0}}) || !w_found) begin
                    w_haz = 1'b0;
                    w_sel = {SEL_W{1'b0}};
                end else if (w_stage < w_rdy) begin
                    w_haz = 1'b1;
                    w_sel = {SEL_W{1'b0}};
`ifndef PARC_SB_WB_BYPASS_EN
                end else if (w_stage == SEL_W'(PIPE_DEPTH)) begin
                    w_haz = 1'b1;
                    w_sel = {SEL_W{1'b0}};
`endif
                end else begin
                    w_haz = 1'b0;
                    w_sel = w_stage;
                end
            end

            assign w_haz_vec[gs]                     = w_haz;
            assign byp_sel_Dhl[gs*SEL_W +: SEL_W]    = w_sel;
        end
    endgenerate

    // Squash overrides the stall so a redirected instruction never holds D.
    assign stall_Dhl = reset & issue_val_Dhl & ~squash_Dhl & (|w_haz_vec);

    assign w_insert = issue_val_Dhl & issue_wen_Dhl & ~stall_Dhl & ~squash_Dhl
                    & (issue_waddr_Dhl != {REG_AW{1'b0}});

    // Shift the in-flight writes one stage per advance; D fills X or inserts a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_val   <= {PIPE_DEPTH{1'b0}};
            r_waddr <= '0;
            r_rdy   <= '0;
        end else if (advance) begin
            for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
                r_val[k]   <= r_val[k-1];
                r_waddr[k] <= r_waddr[k-1];
                r_rdy[k]   <= r_rdy[k-1];
            end
            r_val[0]   <= w_insert;
            r_waddr[0] <= w_insert ? issue_waddr_Dhl : {REG_AW{1'b0}};
            r_rdy[0]   <= w_insert ? w_lat : {SEL_W{1'b0}};
        end else begin
            r_val   <= r_val;
            r_waddr <= r_waddr;
            r_rdy   <= r_rdy;
        end
    end

    // Saturating count of stalled D cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (stall_Dhl && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_parc_bypass_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_parc_bypass_scoreboard
//   Directed scenarios with constant expectations, then randomized traffic
//   checked against an in-flight-instruction queue model.
// ---------------------------------------------------------------------------
module tb_parc_bypass_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_val = 1'b0;
    logic        issue_wen = 1'b0;
    logic [4:0]  issue_waddr = 5'd0;
    logic [1:0]  issue_lat = 2'd0;
    logic        squash = 1'b0;
    logic [1:0]  src_val = 2'b00;
    logic [9:0]  src_addr = 10'd0;
    logic        advance = 1'b0;
    logic        stall_Dhl;
    logic [3:0]  byp_sel_Dhl;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    parc_bypass_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .issue_val_Dhl   (issue_val),
        .issue_wen_Dhl   (issue_wen),
        .issue_waddr_Dhl (issue_waddr),
        .issue_lat_Dhl   (issue_lat),
        .squash_Dhl      (squash),
        .src_val_Dhl     (src_val),
        .src_addr_Dhl    (src_addr),
        .advance         (advance),
        .stall_Dhl       (stall_Dhl),
        .byp_sel_Dhl     (byp_sel_Dhl),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // pq[i] is the instruction currently i+1 stages past D.
    typedef struct {
        bit       val;
        int       waddr;
        int       ready_stage;
    } inst_t;
    inst_t       pq[$];
    longint      m_cnt;

    function automatic void model_reset();
        inst_t b;
        b.val = 0; b.waddr = 0; b.ready_stage = 0;
        pq.delete();
        for (int i = 0; i < 3; i++) pq.push_back(b);
        m_cnt = 0;
    endfunction

    function automatic void model_eval(output bit stall, output logic [3:0] sel);
        bit haz;
        int a;
        int hit;
        int stage;
        bit ok;
        haz = 0;
        sel = 4'd0;
        for (int s = 0; s < 2; s++) begin
            a   = int'(src_addr[s*5 +: 5]);
            hit = -1;
            if (src_val[s] && a != 0) begin
                for (int i = 0; i < pq.size(); i++)
                    if (hit < 0 && pq[i].val && pq[i].waddr == a) hit = i;
                if (hit >= 0) begin
                    stage = hit + 1;
                    ok = (stage >= pq[hit].ready_stage);
`ifndef PARC_SB_WB_BYPASS_EN
                    if (stage == 3) ok = 0;
`endif
                    if (ok) sel[s*2 +: 2] = 2'(stage);
                    else    haz = 1;
                end
            end
        end
        if (!reset) sel = 4'd0;
        stall = reset && issue_val && !squash && haz;
    endfunction

    function automatic void model_clock();
        bit         st;
        logic [3:0] unused_sel;
        inst_t      e;
        if (!reset) begin
            model_reset();
        end else begin
            model_eval(st, unused_sel);
            if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (advance) begin
                e.val   = issue_val && issue_wen && !st && !squash && issue_waddr != 5'd0;
                e.waddr = int'(issue_waddr);
                e.ready_stage = (issue_lat == 2'd0) ? 1 : int'(issue_lat);
                pq.push_front(e);
                void'(pq.pop_back());
            end
        end
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_in(input bit iv, input bit wen, input int wa, input int lat,
                          input bit sq, input bit [1:0] sv, input int a0, input int a1,
                          input bit adv);
        issue_val   = iv;
        issue_wen   = wen;
        issue_waddr = 5'(wa);
        issue_lat   = 2'(lat);
        squash      = sq;
        src_val     = sv;
        src_addr    = {5'(a1), 5'(a0)};
        advance     = adv;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        set_in(1, 1, 3, 1, 0, 2'b11, 3, 3, 1);
        tick();
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall_Dhl); end
        n_checks++;
        if (byp_sel_Dhl !== 4'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", byp_sel_Dhl); end
        n_checks++;
        if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        reset = 1'b1;
        #1;
        idle(3);
    endtask

    task automatic test_bypass_x();
        do_reset();
        set_in(1, 1, 3, 1, 0, 2'b00, 0, 0, 1);
        tick();
        set_in(1, 0, 0, 0, 0, 2'b01, 3, 0, 1);
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL bypx_stall: got %0b want 0", stall_Dhl); end
        n_checks++;
        if (byp_sel_Dhl[1:0] !== 2'd1) begin n_fail++; $display("FAIL bypx_sel0: got %0d want 1", byp_sel_Dhl[1:0]); end
        tick();
    endtask

    task automatic test_load_use();
        set_in(1, 1, 4, 2, 0, 2'b00, 0, 0, 1);
        tick();
        set_in(1, 0, 0, 0, 0, 2'b10, 0, 4, 1);
        n_checks++;
        if (stall_Dhl !== 1'b1) begin n_fail++; $display("FAIL lduse_stall1: got %0b want 1", stall_Dhl); end
        tick();
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL lduse_stall2: got %0b want 0", stall_Dhl); end
        n_checks++;
        if (byp_sel_Dhl[3:2] !== 2'd2) begin n_fail++; $display("FAIL lduse_sel1: got %0d want 2", byp_sel_Dhl[3:2]); end
        n_checks++;
        if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lduse_cnt: got %0d want 1", stall_cnt); end
        tick();
        idle(3);
    endtask

    task automatic test_youngest_and_r0();
        set_in(1, 1, 5, 2, 0, 2'b00, 0, 0, 1);
        tick();
        set_in(1, 1, 5, 1, 0, 2'b00, 0, 0, 1);
        tick();
        set_in(1, 1, 0, 1, 0, 2'b01, 5, 0, 1);
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL young_stall: got %0b want 0", stall_Dhl); end
        n_checks++;
        if (byp_sel_Dhl[1:0] !== 2'd1) begin n_fail++; $display("FAIL young_sel0: got %0d want 1", byp_sel_Dhl[1:0]); end
        tick();
        // r0 write was issued above: it must neither bypass nor stall
        set_in(1, 0, 0, 0, 0, 2'b11, 0, 5, 1);
        n_checks++;
        if (byp_sel_Dhl !== 4'b1000) begin n_fail++; $display("FAIL r0_sel: got %0h want 8", byp_sel_Dhl); end
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %0b want 0", stall_Dhl); end
        idle(3);
    endtask

    task automatic test_hold_and_reset();
        do_reset();
        set_in(1, 1, 4, 2, 0, 2'b00, 0, 0, 1);
        tick();
        set_in(1, 0, 0, 0, 0, 2'b01, 4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (stall_Dhl !== 1'b1) begin n_fail++; $display("FAIL hold_stall[%0d]: got %0b want 1", i, stall_Dhl); end
            tick();
        end
        n_checks++;
        if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL hold_cnt: got %0d want 3", stall_cnt); end
        n_checks++;
        if (stall_Dhl !== 1'b1) begin n_fail++; $display("FAIL hold_still: got %0b want 1", stall_Dhl); end
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %0b want 0", stall_Dhl); end
        n_checks++;
        if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_cnt: got %0d want 0", stall_cnt); end
        reset = 1'b1;
        set_in(1, 0, 0, 0, 0, 2'b01, 4, 0, 1);
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL postrst_stall: got %0b want 0", stall_Dhl); end
        idle(3);
    endtask

    task automatic test_wb_stage();
        set_in(1, 1, 6, 1, 0, 2'b00, 0, 0, 1);
        tick();
        idle(2);
        set_in(1, 0, 0, 0, 0, 2'b01, 6, 0, 1);
`ifdef PARC_SB_WB_BYPASS_EN
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL wb_stall: got %0b want 0", stall_Dhl); end
        n_checks++;
        if (byp_sel_Dhl[1:0] !== 2'd3) begin n_fail++; $display("FAIL wb_sel0: got %0d want 3", byp_sel_Dhl[1:0]); end
`else
        n_checks++;
        if (stall_Dhl !== 1'b1) begin n_fail++; $display("FAIL wb_stall: got %0b want 1", stall_Dhl); end
        n_checks++;
        if (byp_sel_Dhl[1:0] !== 2'd0) begin n_fail++; $display("FAIL wb_sel0: got %0d want 0", byp_sel_Dhl[1:0]); end
`endif
        tick();
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL wb_after_stall: got %0b want 0", stall_Dhl); end
        n_checks++;
        if (byp_sel_Dhl[1:0] !== 2'd0) begin n_fail++; $display("FAIL wb_after_sel0: got %0d want 0", byp_sel_Dhl[1:0]); end
        idle(3);
    endtask

    task automatic test_squash();
        set_in(1, 1, 7, 2, 0, 2'b00, 0, 0, 1);
        tick();
        // squashed D reads r7 (would stall) and tries to write r8
        set_in(1, 1, 8, 1, 1, 2'b01, 7, 0, 1);
        n_checks++;
        if (stall_Dhl !== 1'b0) begin n_fail++; $display("FAIL squash_stall: got %0b want 0", stall_Dhl); end
        tick();
        set_in(1, 0, 0, 0, 0, 2'b11, 8, 7, 1);
        n_checks++;
        if (byp_sel_Dhl !== 4'b1000) begin n_fail++; $display("FAIL squash_sel: got %0h want 8", byp_sel_Dhl); end
        idle(3);
    endtask

    task automatic test_random();
        bit         es;
        logic [3:0] esel;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(9, 0) < 7, $urandom_range(1, 0) == 1,
                   int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                   $urandom_range(9, 0) == 0, 2'($urandom_range(3, 0)),
                   int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                   $urandom_range(9, 0) < 8);
            model_eval(es, esel);
            n_checks++;
            if (stall_Dhl !== es) begin n_fail++; $display("FAIL rnd_stall c=%0d: got %0b want %0b", c, stall_Dhl, es); end
            n_checks++;
            if (byp_sel_Dhl !== esel) begin n_fail++; $display("FAIL rnd_sel c=%0d: got %0h want %0h", c, byp_sel_Dhl, esel); end
            n_checks++;
            if (stall_cnt !== 32'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, stall_cnt, m_cnt); end
            tick();
        end
    endtask

    initial begin
        model_reset();
        #2;
        test_reset();
        test_bypass_x();
        test_load_use();
        test_youngest_and_r0();
        test_hold_and_reset();
        test_wb_stage();
        test_squash();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
